// File: rtl/axi_ram_fill_if.sv
// axi_ram_fill_if: AXI4 write-only channel bundle (AW, W, B) for the RAM fill controller
interface axi_ram_fill_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8
);
  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awlock;
  logic [3:0]            awcache;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;
  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );
  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_ram_fill_ctrl.sv
// axi_ram_fill_ctrl: fills a RAM region over AXI4 with constant or incrementing words in 4KB-safe bursts
module axi_ram_fill_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 16,
  parameter int STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int ID_WIDTH      = 8,
  parameter int MAX_BURST_LEN = 16,
  parameter int AXI_ID        = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  input  logic [ADDR_WIDTH-1:0] cfg_count,
  input  logic [DATA_WIDTH-1:0] cfg_data,
  input  logic                  cfg_incr,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  axi_ram_fill_if.master        m_axi
);
  localparam int LG = $clog2(STRB_WIDTH);
  if (DATA_WIDTH != STRB_WIDTH * 8 || (STRB_WIDTH & (STRB_WIDTH - 1)) != 0) begin : g_bad_strb
    $error("axi_ram_fill_ctrl: STRB_WIDTH must be DATA_WIDTH/8 and a power of two");
  end
  if (MAX_BURST_LEN < 1 || MAX_BURST_LEN > 256) begin : g_bad_len
    $error("axi_ram_fill_ctrl: MAX_BURST_LEN must be 1..256");
  end
  if (ADDR_WIDTH > 32) begin : g_bad_addr
    $error("axi_ram_fill_ctrl: ADDR_WIDTH must be at most 32");
  end
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] addr, addr_n, rem, rem_n, start_addr, next_addr, next_rem;
  logic [DATA_WIDTH-1:0] data, data_n;
  logic                  incr, incr_n;
  logic [8:0]            beats, beats_n, cnt, cnt_n, first_beats, next_beats;
  logic [7:0]            awlen, awlen_n;
  logic busy_n, done_n, error_n, awvalid, awvalid_n, wvalid, wvalid_n, wlast, wlast_n, bready, bready_n;
  logic unused_bid;
  // beats = min(remaining, MAX_BURST_LEN, words left before the next 4KB page)
  function automatic logic [8:0] burst_beats(input logic [ADDR_WIDTH-1:0] a, input logic [ADDR_WIDTH-1:0] r);
    logic [31:0] room, n;
    room = (32'h1000 - (32'(a) & 32'hFFF)) >> LG;
    n = 32'(r) < room ? 32'(r) : room;
    return n < 32'(MAX_BURST_LEN) ? n[8:0] : 9'(MAX_BURST_LEN);
  endfunction
  assign start_addr  = cfg_addr & ~ADDR_WIDTH'(STRB_WIDTH - 1);
  assign next_addr   = addr + (ADDR_WIDTH'(beats) << LG);
  assign next_rem    = rem - ADDR_WIDTH'(beats);
  assign first_beats = burst_beats(start_addr, cfg_count);
  assign next_beats  = burst_beats(next_addr, next_rem);
  always_comb begin
    state_n   = state;
    addr_n    = addr;
    rem_n     = rem;
    data_n    = data;
    incr_n    = incr;
    beats_n   = beats;
    cnt_n     = cnt;
    awlen_n   = awlen;
    busy_n    = busy;
    done_n    = 1'b0;
    error_n   = error;
    awvalid_n = awvalid;
    wvalid_n  = wvalid;
    wlast_n   = wlast;
    bready_n  = bready;
    case (state)
      IDLE: if (start) begin
        error_n = 1'b0;
        if (cfg_count == '0) done_n = 1'b1;
        else begin
          addr_n    = start_addr;
          rem_n     = cfg_count;
          data_n    = cfg_data;
          incr_n    = cfg_incr;
          beats_n   = first_beats;
          awlen_n   = 8'(first_beats - 9'd1);
          busy_n    = 1'b1;
          awvalid_n = 1'b1;
          state_n   = ADDR;
        end
      end
      ADDR: if (m_axi.awready) begin
        awvalid_n = 1'b0;
        wvalid_n  = 1'b1;
        wlast_n   = beats == 9'd1;
        cnt_n     = beats;
        state_n   = DATA;
      end
      DATA: if (m_axi.wready) begin
        data_n  = data + DATA_WIDTH'(incr);
        cnt_n   = cnt - 9'd1;
        wlast_n = cnt == 9'd2;
        if (wlast) begin
          wvalid_n = 1'b0;
          wlast_n  = 1'b0;
          bready_n = 1'b1;
          state_n  = RESP;
        end
      end
      RESP: if (m_axi.bvalid) begin
        bready_n = 1'b0;
        error_n  = error | (m_axi.bresp != 2'b00);
        addr_n   = next_addr;
        rem_n    = next_rem;
        if (next_rem == '0) begin
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          beats_n   = next_beats;
          awlen_n   = 8'(next_beats - 9'd1);
          awvalid_n = 1'b1;
          state_n   = ADDR;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      wlast   <= 1'b0;
      bready  <= 1'b0;
    end else begin
      state   <= state_n;
      busy    <= busy_n;
      done    <= done_n;
      error   <= error_n;
      awvalid <= awvalid_n;
      wvalid  <= wvalid_n;
      wlast   <= wlast_n;
      bready  <= bready_n;
    end
  end
  always_ff @(posedge clk) begin
    addr  <= addr_n;
    rem   <= rem_n;
    data  <= data_n;
    incr  <= incr_n;
    beats <= beats_n;
    cnt   <= cnt_n;
    awlen <= awlen_n;
  end
  assign m_axi.awid    = ID_WIDTH'(AXI_ID);
  assign m_axi.awaddr  = addr;
  assign m_axi.awlen   = awlen;
  assign m_axi.awsize  = 3'(LG);
  assign m_axi.awburst = 2'b01;
  assign m_axi.awlock  = 1'b0;
  assign m_axi.awcache = 4'b0011;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = awvalid;
  assign m_axi.wdata   = data;
  assign m_axi.wstrb   = '1;
  assign m_axi.wlast   = wlast;
  assign m_axi.wvalid  = wvalid;
  assign m_axi.bready  = bready;
  assign unused_bid    = ^m_axi.bid;
endmodule
